// File: rtl/conv11_pkg.sv
// Shared definitions for the 1x1 convolution accumulator slice.
// Holds the default datapath widths and the FSM state encoding.
package conv11_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_W_W    = 8;
    localparam int DEF_ACC_W  = 24;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACC  = 2'd1;
    localparam state_t ST_OUT  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/conv11_quant.sv
// Output quantiser: arithmetic right shift, clamp to the signed output range,
// then an optional ReLU (enabled by defining CONV11_RELU_EN).
module conv11_quant
    import conv11_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = 8
) (
    input  logic signed [ACC_W-1:0]  i_value,
    output logic signed [DATA_W-1:0] o_value
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0]  w_shifted;
    logic signed [DATA_W-1:0] w_sat;

    assign w_shifted = i_value >>> SHIFT;

    // Clamp the shifted value into the representable output range
    always_comb begin
        w_sat = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

`ifdef CONV11_RELU_EN
    assign o_value = w_sat[DATA_W-1] ? '0 : w_sat;
`else
    assign o_value = w_sat;
`endif

endmodule

// File: rtl/conv11_accum.sv
// 1x1 convolution accumulator: sums IN_CH channel products per pixel, adds a
// bias, quantises and hands the result downstream, for NUM_PIX pixels per run.
// Optional ReLU on the output is selected by defining CONV11_RELU_EN.
module conv11_accum
    import conv11_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int W_W     = DEF_W_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int IN_CH   = 16,
    parameter int NUM_PIX = 64,
    parameter int SHIFT   = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              done,
    input  logic                              valid_in,
    output logic                              ready_out,
    input  logic signed [DATA_W-1:0]          data_in,
    input  logic signed [W_W-1:0]             weight_in,
    input  logic signed [ACC_W-1:0]           bias_in,
    output logic [$clog2(IN_CH)-1:0]          ch_idx,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic signed [DATA_W-1:0]          data_out
);

    localparam int CH_W   = $clog2(IN_CH);
    localparam int PIX_W  = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int PROD_W = DATA_W + W_W;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(IN_CH - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);

    state_t                   r_state;
    logic signed [ACC_W-1:0]  r_acc;
    logic [CH_W-1:0]          r_chIdx;
    logic [PIX_W-1:0]         r_pixCnt;
    logic signed [DATA_W-1:0] r_dataOut;
    logic                     r_validOut;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prodExt;
    logic signed [ACC_W-1:0]  w_accNext;
    logic signed [ACC_W-1:0]  w_preQuant;
    logic signed [DATA_W-1:0] w_quant;
    logic                     w_beat;

    // Full-precision product, sign-extended into the wrapping accumulator
    assign w_prod     = PROD_W'(data_in) * PROD_W'(weight_in);
    assign w_prodExt  = ACC_W'(w_prod);
    assign w_accNext  = r_acc + w_prodExt;
    assign w_preQuant = w_accNext + bias_in;
    assign w_beat     = valid_in && (r_state == ST_ACC);

    conv11_quant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_quant (
        .i_value (w_preQuant),
        .o_value (w_quant)
    );

    // Run sequencing, channel accumulation and the registered pixel output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_chIdx    <= '0;
            r_pixCnt   <= '0;
            r_dataOut  <= '0;
            r_validOut <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_ACC;
                        r_acc    <= '0;
                        r_chIdx  <= '0;
                        r_pixCnt <= '0;
                    end
                end
                ST_ACC: begin
                    if (w_beat) begin
                        r_acc <= w_accNext;
                        if (r_chIdx == LAST_CH) begin
                            r_chIdx    <= '0;
                            r_state    <= ST_OUT;
                            r_dataOut  <= w_quant;
                            r_validOut <= 1'b1;
                        end else begin
                            r_chIdx <= r_chIdx + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    if (ready_in) begin
                        r_validOut <= 1'b0;
                        r_acc      <= '0;
                        r_chIdx    <= '0;
                        if (r_pixCnt == LAST_PIX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_pixCnt <= r_pixCnt + 1'b1;
                            r_state  <= ST_ACC;
                        end
                    end
                end
                ST_DONE: begin
                    r_pixCnt <= '0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_out = (r_state == ST_ACC);
    assign done      = (r_state == ST_DONE);
    assign ch_idx    = r_chIdx;
    assign valid_out = r_validOut;
    assign data_out  = r_dataOut;

endmodule

// File: tb/tb_conv11_accum.sv
// Self-checking bench for conv11_accum. Two instances share the stimulus and
// differ only in SHIFT so the shift path is exercised alongside saturation.
module tb_conv11_accum;

    localparam int DW   = 8;
    localparam int WW   = 8;
    localparam int AW   = 24;
    localparam int NCH  = 16;
    localparam int NPIX = 3;
    localparam int SHA  = 0;
    localparam int SHB  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 valid_in;
    logic                 ready_in;
    logic signed [DW-1:0] data_in;
    logic signed [WW-1:0] weight_in;
    logic signed [AW-1:0] bias_in;

    logic                 doneA, readyOutA, validOutA;
    logic [3:0]           chIdxA;
    logic signed [DW-1:0] dataOutA;
    logic                 doneB, readyOutB, validOutB;
    logic [3:0]           chIdxB;
    logic signed [DW-1:0] dataOutB;

    int nCompared   = 0;
    int nMismatched = 0;

    int pixData[NCH];
    int pixWeight[NCH];
    int pixBias;

    conv11_accum #(
        .DATA_W(DW), .W_W(WW), .ACC_W(AW), .IN_CH(NCH), .NUM_PIX(NPIX), .SHIFT(SHA)
    ) dutA (
        .clk(clk), .rst(rst), .start(start), .done(doneA),
        .valid_in(valid_in), .ready_out(readyOutA),
        .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
        .ch_idx(chIdxA), .valid_out(validOutA), .ready_in(ready_in), .data_out(dataOutA)
    );

    conv11_accum #(
        .DATA_W(DW), .W_W(WW), .ACC_W(AW), .IN_CH(NCH), .NUM_PIX(NPIX), .SHIFT(SHB)
    ) dutB (
        .clk(clk), .rst(rst), .start(start), .done(doneB),
        .valid_in(valid_in), .ready_out(readyOutB),
        .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in),
        .ch_idx(chIdxB), .valid_out(validOutB), .ready_in(ready_in), .data_out(dataOutB)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference: dot product plus bias, wrapped to the accumulator width
    function automatic longint refSum();
        longint s;
        s = longint'(pixBias);
        for (int i = 0; i < NCH; i++) s += longint'(pixData[i]) * longint'(pixWeight[i]);
        s = s & 64'sh0000_0000_00FF_FFFF;
        if (s >= 64'sh80_0000) s -= 64'sh100_0000;
        return s;
    endfunction

    // Reference: shift, clamp to the signed output range, optional ReLU
    function automatic int refQuant(input longint sum, input int shift);
        longint s;
        s = sum >>> shift;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef CONV11_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill one pixel's channel data: 0 twos/threes, 1 max positive,
    // 2 max negative, 3 small random, 4 full-range random
    task automatic setPixel(input int mode);
        for (int i = 0; i < NCH; i++) begin
            case (mode)
                0: begin pixData[i] = 2;   pixWeight[i] = 3;    end
                1: begin pixData[i] = 127; pixWeight[i] = 127;  end
                2: begin pixData[i] = 127; pixWeight[i] = -127; end
                3: begin
                    pixData[i]   = int'($urandom_range(0, 20)) - 10;
                    pixWeight[i] = int'($urandom_range(0, 20)) - 10;
                end
                default: begin
                    pixData[i]   = int'($urandom_range(0, 255)) - 128;
                    pixWeight[i] = int'($urandom_range(0, 255)) - 128;
                end
            endcase
        end
        pixBias = (mode <= 2) ? 0 : int'($urandom_range(0, 400)) - 200;
        bias_in = AW'(pixBias);
    endtask

    // Feed up to nBeats channel beats, optionally with valid gaps and a stray start
    task automatic applyStimulus(input bit gaps, input bit pulseStart, input int nBeats);
        for (int b = 0; b < nBeats; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid_in = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    check("gap_ch_idx", chIdxA, b);
                    check("gap_ready_out", readyOutA, 1);
                end
            end
            valid_in  = 1'b1;
            data_in   = DW'(pixData[b]);
            weight_in = WW'(pixWeight[b]);
            start     = pulseStart && (b == 5);
            check("beat_ready_out", readyOutA, 1);
            check("beat_ch_idx", chIdxA, b);
            tick();
            start = 1'b0;
        end
        valid_in = 1'b0;
    endtask

    // Check the pixel result through hold cycles of backpressure and the transfer
    task automatic checkOutput(input int hold, input bit last);
        longint s;
        int expA, expB;
        s    = refSum();
        expA = refQuant(s, SHA);
        expB = refQuant(s, SHB);
        for (int k = 0; k < hold; k++) begin
            ready_in = 1'b0;
            check("hold_valid_out", validOutA, 1);
            check("hold_data_out_a", dataOutA, expA);
            check("hold_data_out_b", dataOutB, expB);
            check("hold_ready_out", readyOutA, 0);
            tick();
        end
        ready_in = 1'b1;
        check("out_valid_out", validOutA, 1);
        check("out_data_out_a", dataOutA, expA);
        check("out_data_out_b", dataOutB, expB);
        tick();
        ready_in = 1'b0;
        check("post_valid_out", validOutA, 0);
        if (last) begin
            check("done_pulse", doneA, 1);
            tick();
            check("done_cleared", doneA, 0);
            check("idle_ready_out", readyOutA, 0);
            tick();
            check("idle_stays", readyOutA, 0);
        end else begin
            check("next_ready_out", readyOutA, 1);
            check("next_ch_idx", chIdxA, 0);
            check("next_done", doneA, 0);
        end
    endtask

    task automatic startRun();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_ready_out", readyOutA, 1);
    endtask

    // Directed sequence of steps
    initial begin
        rst = 1'b1; start = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        data_in = '0; weight_in = '0; bias_in = '0;
        repeat (2) tick();
        check("rst_valid_out", validOutA, 0);
        check("rst_done", doneA, 0);
        check("rst_ready_out", readyOutA, 0);
        check("rst_ch_idx", chIdxA, 0);
        check("rst_data_out", dataOutA, 0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_ready_out", readyOutA, 0);
        check("idle_valid_out", validOutA, 0);
        check("idle_done", doneA, 0);

        $display("[TB] run 1: constant, saturation and backpressure pixels");
        startRun();
        setPixel(0); applyStimulus(1'b0, 1'b0, NCH); checkOutput(5, 1'b0);
        setPixel(1); applyStimulus(1'b0, 1'b0, NCH); checkOutput(0, 1'b0);
        setPixel(2); applyStimulus(1'b0, 1'b0, NCH); checkOutput(1, 1'b1);

        $display("[TB] run 2: random data with valid gaps and a stray start");
        startRun();
        setPixel(3); applyStimulus(1'b1, 1'b1, NCH); checkOutput($urandom_range(0, 3), 1'b0);
        setPixel(4); applyStimulus(1'b1, 1'b0, NCH); checkOutput($urandom_range(0, 3), 1'b0);
        setPixel(3); applyStimulus(1'b1, 1'b1, NCH); checkOutput($urandom_range(0, 3), 1'b1);

        $display("[TB] run 3: reset after the 7th beat of pixel 2");
        startRun();
        setPixel(3); applyStimulus(1'b0, 1'b0, NCH); checkOutput(0, 1'b0);
        setPixel(3); applyStimulus(1'b0, 1'b0, NCH); checkOutput(0, 1'b0);
        setPixel(3); applyStimulus(1'b0, 1'b0, 7);
        rst = 1'b1;
        #1;
        check("midrst_valid_out", validOutA, 0);
        check("midrst_ready_out", readyOutA, 0);
        check("midrst_ch_idx", chIdxA, 0);
        check("midrst_data_out", dataOutA, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("after_rst_quiet", {validOutA, doneA, readyOutA}, 0);
            tick();
        end

        $display("[TB] run 4: fresh run after reset");
        startRun();
        for (int p = 0; p < NPIX; p++) begin
            setPixel(3 + (p % 2));
            applyStimulus(1'b1, 1'b0, NCH);
            checkOutput($urandom_range(0, 2), p == NPIX - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/conv11_accum.md
CONV11_ACCUM -- requirements
Module: conv11_accum

Interface
REQ-001 Parameter DATA_W, default 8, width of signed activation in and out.
REQ-002 Parameter W_W, default 8, width of signed weight.
REQ-003 Parameter ACC_W, default 24, width of signed accumulator and bias.
REQ-004 Parameter IN_CH, default 16, number of input channels per pixel (>=2).
REQ-005 Parameter NUM_PIX, default 64, number of pixels per run (>=1).
REQ-006 Parameter SHIFT, default 8, arithmetic right-shift applied before saturation.
REQ-007 clk  in  1  clock, all state on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 start  in  1  begin a run of NUM_PIX pixels.
REQ-010 done  out  1  one-cycle pulse when the run completes.
REQ-011 valid_in  in  1  data_in and weight_in are valid.
REQ-012 ready_out  out  1  block accepts an input beat.
REQ-013 data_in  in  DATA_W  signed activation, one input channel per beat.
REQ-014 weight_in  in  W_W  signed weight for channel ch_idx, same cycle as data_in.
REQ-015 bias_in  in  ACC_W  signed bias, sampled on the cycle the pixel result is formed.
REQ-016 ch_idx  out  clog2(IN_CH)  current channel index, used to address the weight store.
REQ-017 valid_out  out  1  data_out is valid.
REQ-018 ready_in  in  1  downstream accepts data_out.
REQ-019 data_out  out  DATA_W  signed quantised pixel result.

Function
REQ-020 FSM states: IDLE, ACC, OUT, DONE.
REQ-021 IDLE->ACC on start; start SHALL be ignored in every other state.
REQ-022 ready_out SHALL be high only in ACC; a beat transfers when valid_in && ready_out.
REQ-023 Each transfer adds the full-precision signed product data_in*weight_in, sign-extended to ACC_W, to acc and increments ch_idx.
REQ-024 acc wraps modulo 2^ACC_W; the block has no overflow detection.
REQ-025 On the IN_CH-th transfer, the FSM SHALL enter OUT on the next cycle, with data_out = sat_DATA_W((acc_final + bias_in) >>> SHIFT) registered and valid_out high (latency 1 cycle after the last beat).
REQ-026 In OUT, data_out and valid_out SHALL hold stable until ready_in is high.
REQ-027 On an OUT transfer: if pix_cnt == NUM_PIX-1, go to DONE; otherwise go to ACC with acc=0, ch_idx=0 and pix_cnt incremented.
REQ-028 DONE SHALL assert done for exactly one cycle, clear pix_cnt and return to IDLE.
REQ-029 Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-030 valid_in gaps in ACC stall accumulation with no state change.

Reset
REQ-031 rst SHALL force state=IDLE, acc=0, ch_idx=0, pix_cnt=0, done=0, valid_out=0, data_out=0, ready_out=0.
REQ-032 rst mid-run SHALL abandon the partial pixel; no done pulse and no valid_out follow.

Configuration
REQ-033 With CONV11_RELU_EN defined, negative saturated results SHALL be output as 0.
REQ-034 Without CONV11_RELU_EN, signed saturated results SHALL pass through unchanged.

Structure
REQ-035 Package conv11_pkg holds the state encoding and the default widths DATA_W, W_W and ACC_W, shared with conv11_input_ctrl.
REQ-036 Sub-module conv11_quant (combinational: shift, saturate, optional ReLU) is instantiated once.

Verification
REQ-037 Check reset: assert rst -> all outputs 0, ready_out=0; after release with start=0, the block stays in IDLE.
REQ-038 Run with IN_CH=16, all data_in=2, weight_in=3, bias=0, SHIFT=0 -> data_out=96 (saturates from 96 to 96? no, 96 < 127), valid_out 1 cycle after the 16th beat.
REQ-039 Saturation: data_in=127, weight_in=127, IN_CH=16, SHIFT=0 -> data_out=127; negate the weights -> data_out=-128 (0 with CONV11_RELU_EN).
REQ-040 Backpressure: hold ready_in=0 for 5 cycles in OUT -> data_out stable and ready_out=0 throughout; one transfer occurs when ready_in rises.
REQ-041 Run with NUM_PIX=3 and random valid_in gaps -> exactly 3 outputs, then done high for 1 cycle, then IDLE; a start pulsed mid-run has no effect.
REQ-042 Assert rst after the 7th beat of pixel 2 -> no valid_out and no done; a fresh start then produces correct results from pixel 0.
